// File: rtl/vx_dp_ram_sched_if.sv
// Request/response bundle between memory clients (master) and vx_dp_ram_sched (slave).
interface vx_dp_ram_sched_if #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  parameter int ADDRW    = 8,
  parameter int BYTEENW  = 4,
  parameter int TAGW     = 4,
  parameter int REQ_SELW = 2
);
  logic [NUM_REQS-1:0]         req_valid;
  logic [NUM_REQS-1:0]         req_rw;
  logic [NUM_REQS*ADDRW-1:0]   req_addr;
  logic [NUM_REQS*BYTEENW-1:0] req_byteen;
  logic [NUM_REQS*DATAW-1:0]   req_data;
  logic [NUM_REQS*TAGW-1:0]    req_tag;
  logic [NUM_REQS-1:0]         req_ready;
  logic                        rsp_valid;
  logic [DATAW-1:0]            rsp_data;
  logic [TAGW-1:0]             rsp_tag;
  logic [REQ_SELW-1:0]         rsp_idx;
  logic                        rsp_ready;

  modport master (
    output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_idx
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_idx
  );
endinterface

// File: rtl/vx_dp_ram_sched.sv
// Shares one byte-enabled 1W/1R RAM among NUM_REQS clients: round-robin write and read
// arbiters plus a credit-gated FWFT response FIFO. Optional macro: DP_RAM_SCHED_FWD_EN.
module vx_dp_ram_sched #(
  parameter int NUM_REQS  = 4,
  parameter int DATAW     = 32,
  parameter int SIZE      = 256,
  parameter int ADDRW     = $clog2(SIZE),
  parameter int BYTEENW   = DATAW / 8,
  parameter int TAGW      = 4,
  parameter int RSP_DEPTH = 2,
  parameter int REQ_SELW  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  vx_dp_ram_sched_if.slave bus
);
  localparam int BYTE_W = DATAW / BYTEENW;
  localparam int PTRW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNTW   = $clog2(RSP_DEPTH + 1);

  logic [ADDRW-1:0]    addr_s   [NUM_REQS];
  logic [BYTEENW-1:0]  byteen_s [NUM_REQS];
  logic [DATAW-1:0]    data_s   [NUM_REQS];
  logic [TAGW-1:0]     tag_s    [NUM_REQS];

  logic [DATAW-1:0]    mem_q       [SIZE];
  logic [DATAW-1:0]    fifo_data_q [RSP_DEPTH];
  logic [TAGW-1:0]     fifo_tag_q  [RSP_DEPTH];
  logic [REQ_SELW-1:0] fifo_idx_q  [RSP_DEPTH];
  logic [REQ_SELW-1:0] wr_rr_q, wr_rr_d, rd_rr_q, rd_rr_d;
  logic [PTRW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;

  logic [NUM_REQS-1:0] wr_cand_s, rd_cand_s;
  logic [REQ_SELW:0]   wr_pick_s, rd_pick_s;
  logic [REQ_SELW-1:0] wr_idx_s, rd_idx_s;
  logic [ADDRW-1:0]    waddr_s, raddr_s;
  logic [DATAW-1:0]    rd_word_s;
  logic                wr_gnt_s, rd_win_s, rd_gnt_s, credit_s, hazard_s, push_s, pop_s;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_unpack
    assign addr_s[i]   = bus.req_addr[i*ADDRW +: ADDRW];
    assign byteen_s[i] = bus.req_byteen[i*BYTEENW +: BYTEENW];
    assign data_s[i]   = bus.req_data[i*DATAW +: DATAW];
    assign tag_s[i]    = bus.req_tag[i*TAGW +: TAGW];
  end

  // Returns {found, index}: first candidate at or after ptr, wrapping.
  function automatic logic [REQ_SELW:0] rr_pick(input logic [NUM_REQS-1:0] cand,
                                                input logic [REQ_SELW-1:0] ptr);
    logic [REQ_SELW:0]   res;
    logic [REQ_SELW-1:0] sel;
    int                  idx;
    res = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQS;
      sel = REQ_SELW'(idx);
      res = cand[sel] ? {1'b1, sel} : res;
    end
    return res;
  endfunction

  function automatic logic [REQ_SELW-1:0] rr_next(input logic [REQ_SELW-1:0] idx);
    return (idx == REQ_SELW'(NUM_REQS - 1)) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [DATAW-1:0] byte_merge(input logic [DATAW-1:0]   old_w,
                                                  input logic [DATAW-1:0]   new_w,
                                                  input logic [BYTEENW-1:0] be);
    logic [DATAW-1:0] res;
    res = old_w;
    for (int b = 0; b < BYTEENW; b++) begin
      res[b*BYTE_W +: BYTE_W] = be[b] ? new_w[b*BYTE_W +: BYTE_W] : old_w[b*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

  assign wr_cand_s = bus.req_valid & bus.req_rw;
  assign rd_cand_s = bus.req_valid & ~bus.req_rw;
  assign wr_pick_s = rr_pick(wr_cand_s, wr_rr_q);
  assign rd_pick_s = rr_pick(rd_cand_s, rd_rr_q);
  assign wr_idx_s  = wr_pick_s[REQ_SELW-1:0];
  assign rd_idx_s  = rd_pick_s[REQ_SELW-1:0];
  assign waddr_s   = addr_s[wr_idx_s];
  assign raddr_s   = addr_s[rd_idx_s];
  assign wr_gnt_s  = resetn & wr_pick_s[REQ_SELW];
  assign rd_win_s  = resetn & rd_pick_s[REQ_SELW];
  // Credit uses start-of-cycle occupancy, so a pop frees its slot only next cycle.
  assign credit_s  = (cnt_q < CNTW'(RSP_DEPTH));
  assign hazard_s  = wr_gnt_s & rd_win_s & (waddr_s == raddr_s);

`ifdef DP_RAM_SCHED_FWD_EN
  assign rd_gnt_s  = rd_win_s & credit_s;
  assign rd_word_s = hazard_s ? byte_merge(mem_q[raddr_s], data_s[wr_idx_s], byteen_s[wr_idx_s])
                              : mem_q[raddr_s];
`else
  assign rd_gnt_s  = rd_win_s & credit_s & ~hazard_s;
  assign rd_word_s = mem_q[raddr_s];
`endif

  assign push_s = rd_gnt_s;
  assign pop_s  = (cnt_q != '0) & bus.rsp_ready;

  // Ready is the per-requester grant from either arbiter.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      bus.req_ready[i] = (wr_gnt_s && (wr_idx_s == REQ_SELW'(i))) ||
                         (rd_gnt_s && (rd_idx_s == REQ_SELW'(i)));
    end
  end

  // Next-state for arbiter pointers and FIFO bookkeeping.
  always_comb begin
    wr_rr_d = wr_gnt_s ? rr_next(wr_idx_s) : wr_rr_q;
    rd_rr_d = rd_gnt_s ? rr_next(rd_idx_s) : rd_rr_q;
    wptr_d  = push_s ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop_s ? ptr_inc(rptr_q) : rptr_q;
    cnt_d   = cnt_q + CNTW'(push_s) - CNTW'(pop_s);
  end

  // Scheduler state and response FIFO storage; the FIFO entry is the registered read port.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_rr_q <= '0;
      rd_rr_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_tag_q[i]  <= '0;
        fifo_idx_q[i]  <= '0;
      end
    end else begin
      wr_rr_q <= wr_rr_d;
      rd_rr_q <= rd_rr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      if (push_s) begin
        fifo_data_q[wptr_q] <= rd_word_s;
        fifo_tag_q[wptr_q]  <= tag_s[rd_idx_s];
        fifo_idx_q[wptr_q]  <= rd_idx_s;
      end
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_gnt_s) begin
      mem_q[waddr_s] <= byte_merge(mem_q[waddr_s], data_s[wr_idx_s], byteen_s[wr_idx_s]);
    end
  end

  assign bus.rsp_valid = (cnt_q != '0);
  assign bus.rsp_data  = fifo_data_q[rptr_q];
  assign bus.rsp_tag   = fifo_tag_q[rptr_q];
  assign bus.rsp_idx   = fifo_idx_q[rptr_q];
endmodule

// File: tb/tb_vx_dp_ram_sched.sv
// Self-checking bench for vx_dp_ram_sched: directed scenarios plus random traffic
// against a queue/array reference model. Honours DP_RAM_SCHED_FWD_EN if defined.
module tb_vx_dp_ram_sched;
  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int SIZE  = 256;
  localparam int AW    = 8;
  localparam int BW    = 4;
  localparam int TW    = 4;
  localparam int DEPTH = 2;
  localparam int SW    = 2;

  logic clk;
  logic resetn;

  vx_dp_ram_sched_if #(.NUM_REQS(N), .DATAW(DW), .ADDRW(AW), .BYTEENW(BW),
                       .TAGW(TW), .REQ_SELW(SW)) bus ();

  vx_dp_ram_sched #(.NUM_REQS(N), .DATAW(DW), .SIZE(SIZE), .ADDRW(AW), .BYTEENW(BW),
                    .TAGW(TW), .RSP_DEPTH(DEPTH), .REQ_SELW(SW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic [1:0]  idx;
  } rsp_t;

  rsp_t        mq[$];
  logic [31:0] mem_m [SIZE];
  int          wptr_m, rptr_m;
  logic        rst_clean;
  int          checks, errors, dut_pops;

  logic [3:0]  v_r, rw_r;
  logic [7:0]  a_r  [N];
  logic [3:0]  be_r [N];
  logic [31:0] d_r  [N];
  logic [3:0]  t_r  [N];
  logic        rsp_rdy;
  logic [3:0]  last_ready;
  logic [31:0] old13;
  int          p0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] cand, input int ptr);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (((cand >> j) & 4'b0001) != 4'b0000) return j;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic rw, input logic [7:0] a, input logic [3:0] be,
                         input logic [31:0] d, input logic [3:0] t);
    v_r[i]  = 1'b1;
    rw_r[i] = rw;
    a_r[i]  = a;
    be_r[i] = be;
    d_r[i]  = d;
    t_r[i]  = t;
  endtask

  task automatic drive();
    bus.req_valid = v_r;
    bus.req_rw    = rw_r;
    bus.rsp_ready = rsp_rdy;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]   = a_r[i];
      bus.req_byteen[i*BW +: BW] = be_r[i];
      bus.req_data[i*DW +: DW]   = d_r[i];
      bus.req_tag[i*TW +: TW]    = t_r[i];
    end
  endtask

  // One clock: predict grants/response from the model, compare mid-cycle, then advance.
  task automatic step();
    int          wg, rg;
    logic        hz;
    logic [3:0]  er;
    logic [31:0] rword;
    rsp_t        e;
    drive();
    #4;
    wg = resetn ? pick(v_r & rw_r, wptr_m) : -1;
    rg = resetn ? pick(v_r & ~rw_r, rptr_m) : -1;
    hz = 1'b0;
    if (wg >= 0 && rg >= 0) hz = (a_r[wg] == a_r[rg]);
    if (mq.size() >= DEPTH) rg = -1;
`ifndef DP_RAM_SCHED_FWD_EN
    if (hz) rg = -1;
`endif
    rword = 32'h0;
    if (rg >= 0) begin
      rword = mem_m[a_r[rg]];
`ifdef DP_RAM_SCHED_FWD_EN
      if (hz) begin
        for (int b = 0; b < BW; b++)
          if (be_r[wg][b]) rword[8*b +: 8] = d_r[wg][8*b +: 8];
      end
`endif
    end
    er = 4'b0000;
    if (wg >= 0) er = er | (4'b0001 << wg);
    if (rg >= 0) er = er | (4'b0001 << rg);
    last_ready = bus.req_ready;
    chk("req_ready", bus.req_ready, er);
    chk("rsp_valid", bus.rsp_valid, (mq.size() != 0));
    if (mq.size() != 0) begin
      chk("rsp_data", bus.rsp_data, mq[0].data);
      chk("rsp_tag", bus.rsp_tag, mq[0].tag);
      chk("rsp_idx", bus.rsp_idx, mq[0].idx);
    end else if (rst_clean) begin
      chk("rst_rsp_data", bus.rsp_data, 32'h0);
      chk("rst_rsp_tag", bus.rsp_tag, 4'h0);
      chk("rst_rsp_idx", bus.rsp_idx, 2'h0);
    end
    if (bus.rsp_valid === 1'b1 && rsp_rdy) dut_pops++;
    @(posedge clk);
    if (!resetn) begin
      mq.delete();
      wptr_m    = 0;
      rptr_m    = 0;
      rst_clean = 1'b1;
    end else begin
      if (mq.size() != 0 && rsp_rdy) void'(mq.pop_front());
      if (rg >= 0) begin
        e.data = rword;
        e.tag  = t_r[rg];
        e.idx  = rg[1:0];
        mq.push_back(e);
        rptr_m    = (rg + 1) % N;
        rst_clean = 1'b0;
        v_r[rg]   = 1'b0;
      end
      if (wg >= 0) begin
        for (int b = 0; b < BW; b++)
          if (be_r[wg][b]) mem_m[a_r[wg]][8*b +: 8] = d_r[wg][8*b +: 8];
        wptr_m  = (wg + 1) % N;
        v_r[wg] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (v_r != 4'b0000 && n < budget) begin
      step();
      n++;
    end
    chk(tag, v_r, 4'b0000);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    rsp_rdy = 1'b1;
    while (mq.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_empty", bus.rsp_valid, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0; dut_pops = 0;
    wptr_m = 0; rptr_m = 0; rst_clean = 1'b1;
    v_r = 4'b0000; rw_r = 4'b0000; rsp_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_r[i] = 8'h0; be_r[i] = 4'h0; d_r[i] = 32'h0; t_r[i] = 4'h0;
    end
    drive();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with requests present: no grants, empty response side.
    set_req(0, 1'b0, 8'd1, 4'h0, 32'h0, 4'h1);
    set_req(1, 1'b1, 8'd2, 4'hF, 32'h12345678, 4'h0);
    repeat (2) step();
    v_r = 4'b0000;
    resetn = 1'b1;

    // Preload addresses 0..15.
    for (int a = 0; a < 16; a++) begin
      set_req(a % N, 1'b1, 8'(a), 4'hF, $urandom, 4'h0);
      run_until_idle(4, "preload_timeout");
    end

    // Round-robin reads from all requesters.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(i), 4'h0, 32'h0, 4'(i + 8));
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_grant", last_ready, 4'b0001 << (k % 4));
      for (int i = 0; i < N; i++)
        if (!v_r[i]) set_req(i, 1'b0, 8'((i + k) % 16), 4'h0, 32'h0, 4'((i + k) % 16));
    end
    v_r = 4'b0000;
    drain(10);

    // Write then read of the same address.
    set_req(0, 1'b1, 8'd5, 4'hF, 32'hDEADBEEF, 4'h0);
    step();
    chk("wr5_grant", last_ready, 4'b0001);
    set_req(1, 1'b0, 8'd5, 4'h0, 32'h0, 4'h7);
    step();
    chk("rd5_grant", last_ready, 4'b0010);
    chk("rd5_valid", bus.rsp_valid, 1'b1);
    chk("rd5_data", bus.rsp_data, 32'hDEADBEEF);
    chk("rd5_idx", bus.rsp_idx, 2'd1);
    chk("rd5_tag", bus.rsp_tag, 4'h7);
    drain(5);

    // Same-cycle write/read hazard on address 9.
    set_req(0, 1'b1, 8'd9, 4'hF, 32'h11223344, 4'h0);
    step();
    set_req(0, 1'b1, 8'd9, 4'h3, 32'hAABBCCDD, 4'h0);
    set_req(1, 1'b0, 8'd9, 4'h0, 32'h0, 4'h3);
    step();
`ifdef DP_RAM_SCHED_FWD_EN
    chk("hz_grant", last_ready, 4'b0011);
`else
    chk("hz_grant", last_ready, 4'b0001);
    step();
    chk("hz_regrant", last_ready, 4'b0010);
`endif
    chk("hz_valid", bus.rsp_valid, 1'b1);
    chk("hz_data", bus.rsp_data, 32'h1122CCDD);
    drain(5);

    // Backpressure: only DEPTH reads fit while the consumer stalls.
    rsp_rdy = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(i), 4'h0, 32'h0, 4'(i + 1));
    p0 = dut_pops;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_stall", last_ready, 4'b0000);
      chk("bp_valid", bus.rsp_valid, 1'b1);
    end
    rsp_rdy = 1'b1;
    run_until_idle(12, "bp_timeout");
    drain(10);
    chk("bp_pops", dut_pops - p0, 4);

    // Reset with responses outstanding.
    rsp_rdy = 1'b0;
    set_req(2, 1'b0, 8'd2, 4'h0, 32'h0, 4'hA);
    set_req(3, 1'b0, 8'd3, 4'h0, 32'h0, 4'hB);
    step();
    step();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(i + 4), 4'h0, 32'h0, 4'(i));
    resetn = 1'b0;
    step();
    chk("rst_ready", last_ready, 4'b0000);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    step();
    chk("rst_ready2", last_ready, 4'b0000);
    resetn = 1'b1;
    rsp_rdy = 1'b1;
    step();
    chk("rst_first_grant", last_ready, 4'b0001);
    run_until_idle(12, "rst_timeout");
    drain(10);

    // Write and read to different addresses in one cycle.
    old13 = mem_m[13];
    set_req(2, 1'b1, 8'd12, 4'hF, 32'hCAFEF00D, 4'h0);
    set_req(3, 1'b0, 8'd13, 4'h0, 32'h0, 4'h5);
    step();
    chk("wr_rd_both", last_ready, 4'b1100);
    chk("wr_rd_old", bus.rsp_data, old13);
    drain(5);
    set_req(1, 1'b0, 8'd12, 4'h0, 32'h0, 4'h6);
    step();
    chk("rd12_new", bus.rsp_data, 32'hCAFEF00D);
    drain(5);

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      rsp_rdy = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++)
        if (!v_r[i] && $urandom_range(1) == 1)
          set_req(i, 1'($urandom_range(1)), 8'($urandom_range(15)), 4'($urandom),
                  $urandom, 4'($urandom));
      step();
    end
    rsp_rdy = 1'b1;
    run_until_idle(40, "rand_timeout");
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
